// File: rtl/multicycle_controller_pkg.sv
// Shared opcodes, select codes and state/class encodings for the multi-cycle RV32I controller.
package multicycle_controller_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALUY   = 2'b10;
  localparam logic [1:0] RES_IMMEXT = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_EXEC_JALR, S_JALR,
    S_LUI, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_LOAD, CLS_STORE, CLS_R, CLS_I, CLS_BRANCH, CLS_JAL, CLS_JALR,
    CLS_LUI, CLS_NONE
  } op_class_e;

  function automatic op_class_e op_class(input logic [6:0] op);
    case (op)
      OP_LOAD:   return CLS_LOAD;
      OP_STORE:  return CLS_STORE;
      OP_R:      return CLS_R;
      OP_IMM:    return CLS_I;
      OP_BRANCH: return CLS_BRANCH;
      OP_JAL:    return CLS_JAL;
      OP_JALR:   return CLS_JALR;
      OP_LUI:    return CLS_LUI;
      default:   return CLS_NONE;
    endcase
  endfunction

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from instruction class and funct fields; also flags unsupported funct3 codes.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [3:0] op_class_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o,
  output logic       legal_o
);

  op_class_e cls;
  assign cls = op_class_e'(op_class_i);

  always_comb begin
    alu_control_o = ALU_ADD;
    legal_o       = 1'b1;
    case (cls)
      CLS_R, CLS_I: begin
        case (funct3_i)
          3'b000:  alu_control_o = (cls == CLS_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_control_o = ALU_AND;
          3'b110:  alu_control_o = ALU_OR;
          3'b100:  alu_control_o = ALU_XOR;
          3'b010:  alu_control_o = ALU_SLT;
          3'b011:  alu_control_o = ALU_SLTU;
          default: legal_o = 1'b0;
        endcase
      end
      CLS_BRANCH: begin
        case (funct3_i)
          3'b000, 3'b001: alu_control_o = ALU_SUB;
          3'b100, 3'b101: alu_control_o = ALU_SLT;
          3'b110, 3'b111: alu_control_o = ALU_SLTU;
          default:        legal_o = 1'b0;
        endcase
      end
      CLS_NONE: legal_o = 1'b0;
      default:  ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM (Moore outputs, pc_write gated by zero in BRANCH).
// Optional ILLEGAL_TRAP_EN: illegal instructions halt the FSM with a sticky illegal flag.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_slc,
  output logic       illegal
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  op_class_e  cls;
  logic [2:0] dec_alu;
  logic       dec_legal;
  logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c;

  assign cls     = op_class(opcode);
  assign imm_slc = imm_sel(opcode);

  alu_decoder u_alu_dec (
    .op_class_i    (cls),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .alu_control_o (dec_alu),
    .legal_o       (dec_legal)
  );

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_REG;
    alu_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUY;
        if (cnt_q == WAIT_LAST) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          cnt_d      = '0;
          state_d    = S_DECODE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if (!dec_legal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d   = S_HALT;
          illegal_d = 1'b1;
`else
          state_d   = S_FETCH;
`endif
        end else begin
          case (cls)
            CLS_LOAD, CLS_STORE: state_d = S_MEM_ADR;
            CLS_R:               state_d = S_EXEC_R;
            CLS_I:               state_d = S_EXEC_I;
            CLS_JAL:             state_d = S_JAL;
            CLS_JALR:            state_d = S_EXEC_JALR;
            CLS_LUI:             state_d = S_LUI;
            CLS_BRANCH:          state_d = S_BRANCH;
            default:             state_d = S_FETCH;
          endcase
        end
      end
      S_MEM_ADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        state_d   = (cls == CLS_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = S_MEM_WB;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_MEM_WB: begin
        result_src  = RES_MDR;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_REG;
        alu_control = dec_alu;
        state_d     = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_IMM;
        alu_control = dec_alu;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        result_src  = RES_ALUOUT;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = SRCA_A;
        alu_src_b   = SRCB_REG;
        result_src  = RES_ALUOUT;
        alu_control = dec_alu;
        // bne, blt, bltu take on !zero (funct3[0]^funct3[2] set); beq, bge, bgeu on zero
        pc_write_c  = zero ^ (funct3[0] ^ funct3[2]);
        state_d     = S_FETCH;
      end
      S_JAL, S_JALR: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write_c = 1'b1;
        state_d    = S_ALU_WB;
      end
      S_EXEC_JALR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        state_d   = S_JALR;
      end
      S_LUI: begin
        result_src  = RES_IMMEXT;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign pc_write  = pc_write_c  & ~rst;
  assign mem_write = mem_write_c & ~rst;
  assign ir_write  = ir_write_c  & ~rst;
  assign reg_write = reg_write_c & ~rst;

endmodule
